exp_result_serializer: RTL and testbench

- Downstream stage of the exponential engine (top_design). Consumes its 21-bit result and done flag.
- Captures each new result on the rising edge of done and queues it in a small FIFO.
- Shifts queued results out as a UART-style serial frame on a single line for the lab's display/host side.
- Single clock domain (cpu_clk). The ref_clk-side adjust logic stays upstream.

---
 rtl/exp_ser_pkg.sv | 24 ++
 rtl/exp_result_serializer_if.sv | 24 ++
 rtl/exp_sync_fifo.sv | 50 +++++
 rtl/exp_result_serializer.sv | 156 +++++++++++++++
 tb/tb_exp_result_serializer.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/exp_ser_pkg.sv
// Shared types and helpers for the exponential-result serializer.
// EXP_SER_PARITY_EN adds an even-parity bit to each frame.
package exp_ser_pkg;

  localparam int unsigned DATA_W = 21;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } ser_state_t;

  function automatic int unsigned frame_len(input int unsigned data_w,
                                            input int unsigned baud_div);
`ifdef EXP_SER_PARITY_EN
    return (data_w + 3) * baud_div;
`else
    return (data_w + 2) * baud_div;
`endif
  endfunction

endpackage

// File: rtl/exp_result_serializer_if.sv
// Result/serial-line bundle between the exponential engine side and the serializer.
interface exp_result_serializer_if #(
  parameter int unsigned DATA_W = exp_ser_pkg::DATA_W,
  parameter int unsigned DEPTH  = 4
);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic              done_in;
  logic [DATA_W-1:0] exp_in;
  logic              tx;
  logic              busy;
  logic [CNT_W-1:0]  fifo_count;
  logic              overflow;

  modport master (
    output done_in, exp_in,
    input  tx, busy, fifo_count, overflow
  );

  modport slave (
    input  done_in, exp_in,
    output tx, busy, fifo_count, overflow
  );
endinterface

// File: rtl/exp_sync_fifo.sv
// Circular-buffer FIFO; a push while full is accepted only alongside a pop.
module exp_sync_fifo #(
  parameter int unsigned DATA_W = exp_ser_pkg::DATA_W,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [DATA_W-1:0]          din,
  output logic [DATA_W-1:0]          dout,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              wr_en;
  logic              rd_en;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);
  assign dout  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/exp_result_serializer.sv
// Captures exponential-engine results on done rising edges and sends them LSB-first
// as start/data/stop serial frames. EXP_SER_PARITY_EN inserts an even-parity bit.
module exp_result_serializer #(
  parameter int unsigned DATA_W   = exp_ser_pkg::DATA_W,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned BAUD_DIV = 16
) (
  input logic                    cpu_clk,
  input logic                    rst,
  exp_result_serializer_if.slave bus
);
  import exp_ser_pkg::*;

  localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
  localparam int unsigned BAUD_W = $clog2(BAUD_DIV);
  localparam int unsigned IDX_W  = $clog2(DATA_W);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);
  localparam logic [IDX_W-1:0]  BIT_LAST  = IDX_W'(DATA_W - 1);

  ser_state_t        state;
  logic              done_prev;
  logic              push;
  logic              pop;
  logic              full;
  logic              empty;
  logic [DATA_W-1:0] head;
  logic [DATA_W-1:0] shift;
  logic [BAUD_W-1:0] baud_cnt;
  logic [IDX_W-1:0]  bit_idx;
  logic [CNT_W-1:0]  count;
  logic              tx_r;
  logic              busy_r;
  logic              overflow_r;
`ifdef EXP_SER_PARITY_EN
  logic              parity;
`endif

  assign push = bus.done_in & ~done_prev;
  assign pop  = (state == IDLE) && !empty;

  assign bus.tx         = tx_r;
  assign bus.busy       = busy_r;
  assign bus.fifo_count = count;
  assign bus.overflow   = overflow_r;

  exp_sync_fifo #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk  (cpu_clk),
    .rst  (rst),
    .push (push),
    .pop  (pop),
    .din  (bus.exp_in),
    .dout (head),
    .count(count),
    .full (full),
    .empty(empty)
  );

  // done_prev resets high so a done level held across reset is not seen as an edge.
  always_ff @(posedge cpu_clk) begin
    if (rst) begin
      done_prev  <= 1'b1;
      overflow_r <= 1'b0;
    end else begin
      done_prev <= bus.done_in;
      if (push && full && !pop) overflow_r <= 1'b1;
    end
  end

  always_ff @(posedge cpu_clk) begin
    if (rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      tx_r     <= 1'b1;
      busy_r   <= 1'b0;
`ifdef EXP_SER_PARITY_EN
      parity   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            shift    <= head;
`ifdef EXP_SER_PARITY_EN
            parity   <= ^head;
`endif
            baud_cnt <= '0;
            state    <= START;
            tx_r     <= 1'b0;
            busy_r   <= 1'b1;
          end
        end
        START: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            state    <= DATA;
            tx_r     <= shift[0];
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            if (bit_idx == BIT_LAST) begin
`ifdef EXP_SER_PARITY_EN
              state <= PARITY;
              tx_r  <= parity;
`else
              state <= STOP;
              tx_r  <= 1'b1;
`endif
            end else begin
              // tx is registered, so it takes the bit that becomes shift[0] after this shift.
              bit_idx <= bit_idx + 1'b1;
              shift   <= shift >> 1;
              tx_r    <= shift[1];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
`ifdef EXP_SER_PARITY_EN
        PARITY: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            state    <= STOP;
            tx_r     <= 1'b1;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
`endif
        STOP: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            state    <= IDLE;
            busy_r   <= 1'b0;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          tx_r   <= 1'b1;
          busy_r <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_exp_result_serializer.sv
// Directed bench: one serializer at BAUD_DIV=4 and one at BAUD_DIV=16, both DEPTH=4.
module tb_exp_result_serializer;
  localparam int unsigned W = 21;
`ifdef EXP_SER_PARITY_EN
  localparam int unsigned PB = 1;
`else
  localparam int unsigned PB = 0;
`endif
  localparam int unsigned FL4  = (W + 2 + PB) * 4;
  localparam int unsigned FL16 = (W + 2 + PB) * 16;

  logic clk = 1'b0;
  logic rst4 = 1'b1;
  logic rst16 = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  exp_result_serializer_if #(.DATA_W(W), .DEPTH(4)) bus4 ();
  exp_result_serializer_if #(.DATA_W(W), .DEPTH(4)) bus16 ();

  exp_result_serializer #(.DATA_W(W), .DEPTH(4), .BAUD_DIV(4)) dut4 (
    .cpu_clk(clk), .rst(rst4), .bus(bus4)
  );
  exp_result_serializer #(.DATA_W(W), .DEPTH(4), .BAUD_DIV(16)) dut16 (
    .cpu_clk(clk), .rst(rst16), .bus(bus16)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected line level c cycles after a frame's start bit begins.
  function automatic logic exp_tx(input logic [W-1:0] v, input int unsigned bd,
                                  input int unsigned c);
    logic [W-1:0] t;
    if (c < bd) return 1'b0;
    if (c < bd * (W + 1)) begin
      t = v >> (c / bd - 1);
      return t[0];
    end
    if (PB != 0 && c < bd * (W + 2)) return ^v;
    return 1'b1;
  endfunction

  task automatic test_reset();
    bus4.done_in = 1'b1;  bus4.exp_in  = 21'h12345;
    bus16.done_in = 1'b1; bus16.exp_in = 21'h0F00F;
    rst4 = 1'b1; rst16 = 1'b1;
    tick(); tick();
    rst4 = 1'b0; rst16 = 1'b0;
    tick(); tick(); tick();
    vectors++; if (bus4.tx !== 1'b1) begin miscompares++; $display("FAIL reset_tx4: got %b want 1", bus4.tx); end
    vectors++; if (bus4.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy4: got %b want 0", bus4.busy); end
    vectors++; if (bus4.fifo_count !== 3'd0) begin miscompares++; $display("FAIL reset_count4: got %0d want 0", bus4.fifo_count); end
    vectors++; if (bus4.overflow !== 1'b0) begin miscompares++; $display("FAIL reset_ovf4: got %b want 0", bus4.overflow); end
    vectors++; if (bus16.tx !== 1'b1) begin miscompares++; $display("FAIL reset_tx16: got %b want 1", bus16.tx); end
    vectors++; if (bus16.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy16: got %b want 0", bus16.busy); end
    vectors++; if (bus16.fifo_count !== 3'd0) begin miscompares++; $display("FAIL reset_count16: got %0d want 0", bus16.fifo_count); end
    vectors++; if (bus16.overflow !== 1'b0) begin miscompares++; $display("FAIL reset_ovf16: got %b want 0", bus16.overflow); end
    bus4.done_in = 1'b0; bus16.done_in = 1'b0;
    tick();
  endtask

  task automatic test_single_frame();
    int bad_c = -1;
    int busy_bad = -1;
    logic bad_v = 1'b0;
    bus4.exp_in = 21'h1ABCDE; bus4.done_in = 1'b1;
    tick();
    vectors++; if (bus4.fifo_count !== 3'd1) begin miscompares++; $display("FAIL single_capture_count: got %0d want 1", bus4.fifo_count); end
    vectors++; if (bus4.tx !== 1'b1) begin miscompares++; $display("FAIL single_tx_before_pop: got %b want 1", bus4.tx); end
    vectors++; if (bus4.busy !== 1'b0) begin miscompares++; $display("FAIL single_busy_before_pop: got %b want 0", bus4.busy); end
    bus4.done_in = 1'b0;
    tick();
    for (int unsigned c = 0; c < FL4; c++) begin
      if (bad_c < 0 && bus4.tx !== exp_tx(21'h1ABCDE, 4, c)) begin bad_c = int'(c); bad_v = bus4.tx; end
      if (busy_bad < 0 && bus4.busy !== 1'b1) busy_bad = int'(c);
      tick();
    end
    vectors++; if (bad_c >= 0) begin miscompares++; $display("FAIL single_frame_tx: cycle %0d got %b want %b", bad_c, bad_v, exp_tx(21'h1ABCDE, 4, bad_c)); end
    vectors++; if (busy_bad >= 0) begin miscompares++; $display("FAIL single_busy_high: busy low at cycle %0d want high for %0d cycles", busy_bad, FL4); end
    vectors++; if (bus4.busy !== 1'b0) begin miscompares++; $display("FAIL single_busy_end: got %b want 0", bus4.busy); end
    vectors++; if (bus4.tx !== 1'b1) begin miscompares++; $display("FAIL single_tx_end: got %b want 1", bus4.tx); end
  endtask

  task automatic test_queueing();
    int bad_c = -1;
    int busy_bad = -1;
    logic bad_v = 1'b0;
    logic exp_v = 1'b0;
    logic [2:0] peak = 3'd0;
    logic [W-1:0] v;
    int unsigned f, r;
    bus4.exp_in = 21'd1; bus4.done_in = 1'b1;
    tick();
    bus4.done_in = 1'b0;
    tick();
    for (int unsigned c = 0; c < 3 * (FL4 + 1); c++) begin
      f = c / (FL4 + 1);
      r = c % (FL4 + 1);
      v = W'(f + 1);
      if (bad_c < 0 && bus4.tx !== ((r == FL4) ? 1'b1 : exp_tx(v, 4, r))) begin
        bad_c = int'(c); bad_v = bus4.tx; exp_v = (r == FL4) ? 1'b1 : exp_tx(v, 4, r);
      end
      if (busy_bad < 0 && bus4.busy !== (r != FL4)) busy_bad = int'(c);
      if (bus4.fifo_count > peak) peak = bus4.fifo_count;
      // Second pulse holds done high for two cycles with exp_in changing; only the edge captures.
      bus4.done_in = (c == 3 || c == 4 || c == 8);
      if (c == 3) bus4.exp_in = 21'd2;
      if (c == 4) bus4.exp_in = 21'h0ABCD;
      if (c == 8) bus4.exp_in = 21'd3;
      tick();
    end
    vectors++; if (bad_c >= 0) begin miscompares++; $display("FAIL queue_stream_tx: cycle %0d got %b want %b", bad_c, bad_v, exp_v); end
    vectors++; if (busy_bad >= 0) begin miscompares++; $display("FAIL queue_busy_pattern: first wrong busy at cycle %0d", busy_bad); end
    vectors++; if (peak !== 3'd2) begin miscompares++; $display("FAIL queue_peak_count: got %0d want 2", peak); end
    vectors++; if (bus4.busy !== 1'b0 || bus4.fifo_count !== 3'd0) begin miscompares++; $display("FAIL queue_drained: busy %b count %0d want 0 0", bus4.busy, bus4.fifo_count); end
  endtask

  task automatic test_overflow();
    int bad_c = -1;
    logic bad_v = 1'b0;
    logic exp_v = 1'b0;
    int busy_seen = 0;
    logic [W-1:0] v;
    int unsigned f, r;
    bus16.exp_in = 21'd10; bus16.done_in = 1'b1;
    tick();
    bus16.done_in = 1'b0;
    tick();
    for (int unsigned c = 0; c < 5 * (FL16 + 1); c++) begin
      f = c / (FL16 + 1);
      r = c % (FL16 + 1);
      v = W'(f + 10);
      if (bad_c < 0 && bus16.tx !== ((r == FL16) ? 1'b1 : exp_tx(v, 16, r))) begin
        bad_c = int'(c); bad_v = bus16.tx; exp_v = (r == FL16) ? 1'b1 : exp_tx(v, 16, r);
      end
      if (c == 8) begin
        vectors++; if (bus16.overflow !== 1'b0 || bus16.fifo_count !== 3'd4) begin miscompares++; $display("FAIL ovf_before_drop: ovf %b count %0d want 0 4", bus16.overflow, bus16.fifo_count); end
      end
      if (c == 9) begin
        vectors++; if (bus16.overflow !== 1'b1 || bus16.fifo_count !== 3'd4) begin miscompares++; $display("FAIL ovf_on_drop: ovf %b count %0d want 1 4", bus16.overflow, bus16.fifo_count); end
      end
      bus16.done_in = (c <= 8 && c % 2 == 0);
      bus16.exp_in  = W'(11 + c / 2);
      tick();
    end
    vectors++; if (bad_c >= 0) begin miscompares++; $display("FAIL ovf_stream_tx: cycle %0d got %b want %b", bad_c, bad_v, exp_v); end
    vectors++; if (bus16.busy !== 1'b0 || bus16.tx !== 1'b1 || bus16.fifo_count !== 3'd0) begin miscompares++; $display("FAIL ovf_drained: busy %b tx %b count %0d want 0 1 0", bus16.busy, bus16.tx, bus16.fifo_count); end
    for (int unsigned c = 0; c < 400; c++) begin
      if (bus16.busy !== 1'b0) busy_seen++;
      tick();
    end
    vectors++; if (busy_seen != 0) begin miscompares++; $display("FAIL ovf_no_sixth_frame: busy for %0d cycles want 0", busy_seen); end
    vectors++; if (bus16.overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_sticky: got %b want 1", bus16.overflow); end
  endtask

  task automatic test_reset_mid_frame();
    int busy_seen = 0;
    int tx_low = 0;
    bus4.exp_in = 21'h0AAAAA; bus4.done_in = 1'b1;
    tick();
    bus4.done_in = 1'b0;
    tick();
    for (int unsigned c = 0; c <= 45; c++) begin
      if (c == 45) begin
        vectors++; if (bus4.tx !== 1'b0 || bus4.busy !== 1'b1 || bus4.fifo_count !== 3'd1) begin miscompares++; $display("FAIL midrst_before: tx %b busy %b count %0d want 0 1 1", bus4.tx, bus4.busy, bus4.fifo_count); end
        rst4 = 1'b1;
      end
      bus4.done_in = (c == 1);
      if (c == 1) bus4.exp_in = 21'h0F0F0;
      tick();
    end
    vectors++; if (bus4.tx !== 1'b1) begin miscompares++; $display("FAIL midrst_tx: got %b want 1", bus4.tx); end
    vectors++; if (bus4.fifo_count !== 3'd0 || bus4.busy !== 1'b0) begin miscompares++; $display("FAIL midrst_state: count %0d busy %b want 0 0", bus4.fifo_count, bus4.busy); end
    rst4 = 1'b0;
    for (int unsigned c = 0; c < 200; c++) begin
      if (bus4.busy !== 1'b0) busy_seen++;
      if (bus4.tx !== 1'b1) tx_low++;
      tick();
    end
    vectors++; if (busy_seen != 0 || tx_low != 0) begin miscompares++; $display("FAIL midrst_quiet: busy %0d txlow %0d cycles want 0 0", busy_seen, tx_low); end
  endtask

`ifdef EXP_SER_PARITY_EN
  task automatic test_parity();
    logic [W-1:0] vals [2];
    logic         pars [2];
    int           busy_cyc;
    int           bad_c;
    vals[0] = 21'h000007; pars[0] = 1'b1;
    vals[1] = 21'h000003; pars[1] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      busy_cyc = 0;
      bad_c = -1;
      bus4.exp_in = vals[i]; bus4.done_in = 1'b1;
      tick();
      bus4.done_in = 1'b0;
      tick();
      for (int unsigned c = 0; c < 100; c++) begin
        if (bus4.busy === 1'b1) busy_cyc++;
        if (c >= 88 && c < 92 && bad_c < 0 && bus4.tx !== pars[i]) bad_c = int'(c);
        tick();
      end
      vectors++; if (bad_c >= 0) begin miscompares++; $display("FAIL parity_bit_%0d: wrong at cycle %0d want %b", i, bad_c, pars[i]); end
      vectors++; if (busy_cyc != 96) begin miscompares++; $display("FAIL parity_frame_len_%0d: got %0d want 96", i, busy_cyc); end
    end
  endtask
`endif

  initial begin
    bus4.done_in = 1'b0;  bus4.exp_in  = '0;
    bus16.done_in = 1'b0; bus16.exp_in = '0;
    test_reset();
    test_single_frame();
    test_queueing();
    test_overflow();
    test_reset_mid_frame();
`ifdef EXP_SER_PARITY_EN
    test_parity();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
